// File: rtl/pc_unit.sv
// Program counter for the single-cycle MIPS datapath: next-PC select (seq/branch/j/jr), retired and redirect counters.
// npc is combinational in the same cycle and pc updates on the next edge; stall holds all state. Optional macro PC_CHECK_EN enables illegal-target checking.
module pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] PC_LO    = 32'h0000_3000,
  parameter logic [31:0] PC_HI    = 32'h0000_6FFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  npc_sel,
  input  logic        br_taken,
  input  logic [15:0] imm16,
  input  logic [25:0] instr_index,
  input  logic [31:0] ra_data,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] npc,
  output logic [31:0] instr_cnt,
  output logic [31:0] taken_cnt,
  output logic        addr_err
);

`ifdef PC_CHECK_EN
  localparam logic CHECK_EN = 1'b1;
`else
  localparam logic CHECK_EN = 1'b0;
`endif

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_cnt_q, instr_cnt_d;
  logic [31:0] taken_cnt_q, taken_cnt_d;
  logic        addr_err_q, addr_err_d;

  logic [31:0] br_target;
  logic [31:0] j_target;
  logic [31:0] npc_c;
  logic        redirect;
  logic        illegal;

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    br_target = pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00};
    j_target  = {pc_q[31:28], instr_index, 2'b00};
    npc_c     = pc_plus4;
    redirect  = 1'b0;
    case (npc_sel)
      2'b01: begin
        npc_c    = br_taken ? br_target : pc_plus4;
        redirect = br_taken;
      end
      2'b10: begin
        npc_c    = j_target;
        redirect = 1'b1;
      end
      2'b11: begin
        npc_c    = ra_data;
        redirect = 1'b1;
      end
      default: begin
        npc_c    = pc_plus4;
        redirect = 1'b0;
      end
    endcase

    // With checking disabled CHECK_EN folds this to a constant 0.
    illegal = CHECK_EN & redirect &
              ((npc_c[1:0] != 2'b00) || (npc_c < PC_LO) || (npc_c > PC_HI));
  end

  always_comb begin
    pc_d        = pc_q;
    instr_cnt_d = instr_cnt_q;
    taken_cnt_d = taken_cnt_q;
    addr_err_d  = addr_err_q;
    if (!stall) begin
      pc_d        = illegal ? pc_plus4 : npc_c;
      instr_cnt_d = instr_cnt_q + 32'd1;
      taken_cnt_d = taken_cnt_q + {31'd0, redirect & ~illegal};
      addr_err_d  = illegal;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q        <= RESET_PC;
      instr_cnt_q <= 32'd0;
      taken_cnt_q <= 32'd0;
      addr_err_q  <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      instr_cnt_q <= instr_cnt_d;
      taken_cnt_q <= taken_cnt_d;
      addr_err_q  <= addr_err_d;
    end
  end

  assign pc        = pc_q;
  assign npc       = npc_c;
  assign instr_cnt = instr_cnt_q;
  assign taken_cnt = taken_cnt_q;
  assign addr_err  = addr_err_q;

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Program-counter stage of the single-cycle MIPS datapath.
- Holds the architectural PC and computes the next PC from four sources: sequential, conditional branch, j/jal, jr.
- The conditional-branch source is gated by the 1-bit taken decision that the branch-decision unit produces from equal/bgtz evaluation.
- Feeds IM address, the jal link path (pc_plus4) and the debug counters.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- PC_LO, 32'h0000_3000, lowest legal instruction address (used only with PC_CHECK_EN).
- PC_HI, 32'h0000_6FFC, highest legal instruction address (used only with PC_CHECK_EN).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  1 = hold PC and counters this cycle.
- npc_sel  input  2  next-PC source: 00 seq, 01 branch, 10 j/jal, 11 jr.
- br_taken  input  1  branch decision (already ANDed with Branch upstream).
- imm16  input  16  branch offset field, instr[15:0].
- instr_index  input  26  jump target field, instr[25:0].
- ra_data  input  32  GPR[rs] value for jr.
- pc  output  32  current PC (registered).
- pc_plus4  output  32  pc + 4, combinational; used as jal link value.
- npc  output  32  selected next PC, combinational.
- instr_cnt  output  32  retired-instruction counter.
- taken_cnt  output  32  taken-redirect counter.
- addr_err  output  1  registered illegal-target flag (0 unless PC_CHECK_EN).

Behaviour:
- Reset (priority over stall): pc=RESET_PC, instr_cnt=0, taken_cnt=0, addr_err=0.
- pc_plus4 = pc + 32'd4, mod 2^32.
- Branch target = pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00}, 32-bit wrap.
- Jump target = {pc[31:28], instr_index, 2'b00}.
- jr target = ra_data, unmodified.
- npc selection:
  - 00 -> pc_plus4.
  - 01 -> branch target if br_taken, else pc_plus4.
  - 10 -> jump target.
  - 11 -> jr target.
- redirect = (npc_sel==01 & br_taken) | npc_sel==10 | npc_sel==11.
- br_taken is ignored when npc_sel != 01.
- Each rising edge with reset=0, stall=0:
  - pc <= npc.
  - instr_cnt <= instr_cnt + 1 (wraps 0xFFFFFFFF -> 0).
  - taken_cnt <= taken_cnt + redirect (wraps).
- With stall=1: pc, instr_cnt, taken_cnt and addr_err hold; npc and pc_plus4 still reflect the current inputs.
- Latency: npc is visible in the same cycle; pc updates one edge later. No multi-cycle operations.
- A branch to itself (imm16=16'hFFFF) gives npc=pc and is a legal redirect; taken_cnt increments every cycle.
- Reset asserted mid-stall or mid-redirect: next edge loads the reset values, and the pending redirect is discarded.

Optional Feature:
- Macro: PC_CHECK_EN.
- Defined:
  - On a non-stalled redirect, the target is illegal if target[1:0]!=0, target<PC_LO or target>PC_HI.
  - Illegal target: pc <= pc_plus4 instead, taken_cnt does not increment, addr_err <= 1 for exactly that one cycle.
  - Otherwise addr_err <= 0.
  - Sequential pc_plus4 beyond PC_HI is not checked.
- Not defined: no checking, targets load as computed, addr_err is tied to 0.

Test Plan:
- Reset for 2 cycles, then release with npc_sel=00 for 3 cycles -> pc 0x3000, 0x3004, 0x3008, 0x300C; instr_cnt=3; taken_cnt=0.
- pc=0x3010, npc_sel=01, imm16=0xFFFC, br_taken=1 -> npc=0x3004, pc=0x3004 next cycle, taken_cnt+1. Same with br_taken=0 -> pc=0x3014, taken_cnt unchanged.
- pc=0x3020, npc_sel=10, instr_index=0x0000C10 -> pc=0x00003040, pc_plus4 was 0x3024 during the jal cycle. Then npc_sel=11, ra_data=0x3024 -> pc=0x3024.
- stall=1 for 3 cycles with npc_sel=10 -> pc and both counters unchanged; first non-stalled cycle applies the jump once.
- Reset asserted while stall=1 at pc=0x3100 -> pc=0x3000, counters 0 after one edge.
- PC_CHECK_EN: jr with ra_data=0x3002 at pc=0x3040 -> pc=0x3044, addr_err=1 for one cycle, taken_cnt unchanged. jr with ra_data=0x7000 behaves the same. Without the macro, pc=0x3002 and addr_err=0.
